shift_serializer: RTL and testbench
===================================

SHIFT_SERIALIZER -- requirements
Module: shift_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: number of data bits per word.
REQ-002 The block SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-004 The block SHALL have port din  input  WIDTH: parallel word to serialize.
REQ-005 The block SHALL have port load_valid  input  1: din is valid and offered for loading.
REQ-006 The block SHALL have port load_ready  output  1: block accepts a word this cycle.
REQ-007 The block SHALL have port d  output  1: serial bit stream, for the downstream shift register's d input.
REQ-008 The block SHALL have port d_valid  output  1: d carries a meaningful bit this cycle.
REQ-009 The block SHALL have port done  output  1: one-cycle pulse in the cycle the final bit of a word is on d.

Function
REQ-010 A word SHALL be accepted on a rising edge where load_valid=1 and load_ready=1; no other condition loads din.
REQ-011 The FSM SHALL have states IDLE, SHIFT and PAR (PAR exists only with the macro in REQ-025).
REQ-012 In IDLE: load_ready=1, d=0, d_valid=0, done=0; an accept moves to SHIFT.
REQ-013 Latency: the first bit SHALL appear on d in the cycle immediately after the accepting edge.
REQ-014 Bit order SHALL be MSB first: din[WIDTH-1] first, din[0] last, one bit per cycle.
REQ-015 In SHIFT: d_valid=1 for exactly WIDTH consecutive cycles; a bit counter of width clog2(WIDTH+1) tracks position.
REQ-016 The word SHALL be held in an internal register; changes on din after acceptance SHALL NOT affect the output.
REQ-017 done SHALL be 1 only in the cycle the last bit of the frame is on d (din[0], or the parity bit under REQ-025).
REQ-018 load_ready SHALL be 1 in IDLE and in the last-bit cycle of a frame, and 0 in every other cycle.
REQ-019 Accept in the last-bit cycle: the next cycle SHALL present the new word's MSB with d_valid=1 and no idle gap.
REQ-020 No accept in the last-bit cycle: the FSM SHALL return to IDLE on the next cycle.
REQ-021 load_valid=1 while load_ready=0 SHALL be ignored, with no state change and no loss of the current word.
REQ-022 With WIDTH=1, every frame SHALL be one SHIFT cycle with done=1 and load_ready=1 in that cycle.

Reset
REQ-023 While reset=1, asynchronously: state=IDLE, shift register=0, counter=0, d=0, d_valid=0, done=0, load_ready=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame; after release the block SHALL sit in IDLE and emit no partial bits.

Configuration
REQ-025 With macro SHIFT_SERIALIZER_PARITY_EN defined, each frame SHALL be followed by one PAR cycle with d = XOR of the word's bits (even parity) and d_valid=1.
REQ-026 With SHIFT_SERIALIZER_PARITY_EN defined, done and the REQ-018 load window SHALL move to the PAR cycle, giving WIDTH+1 cycles per frame.
REQ-027 Without SHIFT_SERIALIZER_PARITY_EN, the PAR state and parity logic SHALL NOT exist, giving WIDTH cycles per frame.

Verification (WIDTH=4, 10 ns clock)
REQ-028 Bench SHALL check: reset held 10 ns with load_valid=1 -> d=0, d_valid=0, done=0, load_ready=1 throughout.
REQ-029 Bench SHALL check: load din=4'b1011 once -> d = 1,0,1,1 on the next 4 cycles with d_valid=1, done=1 on the 4th cycle only, then IDLE; downstream SIPO q=4'b1011.
REQ-030 Bench SHALL check: 4'b1100 then 4'b0110 offered back-to-back with load_valid held high -> 8 contiguous valid bits 1,1,0,0,0,1,1,0 with no gap and two done pulses.
REQ-031 Bench SHALL check: load_valid pulsed in cycle 2 of a frame with din=4'b1111 -> ignored; output bits are unchanged and load_ready=0 in that cycle.
REQ-032 Bench SHALL check: reset asserted after 2 bits of 4'b1010 -> outputs immediately 0 and IDLE; a subsequent load of 4'b0001 serializes correctly.
REQ-033 Bench SHALL check, with SHIFT_SERIALIZER_PARITY_EN defined: load 4'b0111 -> d = 0,1,1,1,1 (parity 1), with done on the 5th cycle.

Source files
------------

// File: rtl/shift_serializer.sv
// shift_serializer: MSB-first parallel-to-serial converter with a ready/valid load port.
// Optional even-parity trailer bit when SHIFT_SERIALIZER_PARITY_EN is defined.
module shift_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             d,
  output logic             d_valid,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef SHIFT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
  logic par_q, par_d;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif
  state_t state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last;
  assign last = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
`ifdef SHIFT_SERIALIZER_PARITY_EN
    par_d      = par_q;
`endif
    d          = 1'b0;
    d_valid    = 1'b0;
    done       = 1'b0;
    load_ready = 1'b0;
    case (state_q)
      IDLE: load_ready = 1'b1;
      SHIFT: begin
        d       = sr_q[WIDTH-1];
        d_valid = 1'b1;
        sr_d    = sr_q << 1;
        cnt_d   = cnt_q + 1'b1;
`ifdef SHIFT_SERIALIZER_PARITY_EN
        state_d = last ? PAR : SHIFT;
`else
        done       = last;
        load_ready = last;
        state_d    = last ? IDLE : SHIFT;
`endif
      end
`ifdef SHIFT_SERIALIZER_PARITY_EN
      PAR: begin
        d          = par_q;
        d_valid    = 1'b1;
        done       = 1'b1;
        load_ready = 1'b1;
        state_d    = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    // an accept in the last-bit cycle overrides the return to IDLE, so frames abut
    if (load_valid && load_ready) begin
      state_d = SHIFT;
      sr_d    = din;
      cnt_d   = '0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
      par_d   = ^din;
`endif
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
`ifdef SHIFT_SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_shift_serializer.sv
// tb_shift_serializer: directed checks of shift_serializer (WIDTH=4) with a downstream SIPO model.
// Parity frame is checked only when SHIFT_SERIALIZER_PARITY_EN is defined.
module tb_shift_serializer;
  logic clk = 1'b0;
  logic reset, load_valid, load_ready, d, d_valid, done;
  logic [3:0] din, sipo_q;
  int n_run = 0;
  int n_fail = 0;
  shift_serializer #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
    .load_ready(load_ready), .d(d), .d_valid(d_valid), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (d_valid) sipo_q <= {sipo_q[2:0], d};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // obs/exp packed as {d, d_valid, done, load_ready}
  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {d, d_valid, done, load_ready};
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  initial begin
    logic [7:0] bits;
    logic [3:0] w;
    sipo_q = '0;
    reset = 1'b1; load_valid = 1'b1; din = 4'b1011;
    #1 chk("reset_t1", 4'b0001);
    #5 chk("reset_t6", 4'b0001);
    #3 chk("reset_t9", 4'b0001);
    #1 reset = 1'b0; load_valid = 1'b0;
    tick();
    chk("idle_after_reset", 4'b0001);
    // single word 1011
    din = 4'b1011; load_valid = 1'b1;
    tick();
    load_valid = 1'b0; din = 4'b0000;
    w = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("w1011_bit%0d", i), {w[3-i], 1'b1, i == 3, i == 3});
      tick();
    end
    chk("w1011_idle", 4'b0001);
    n_run++;
    assert (sipo_q === 4'b1011) else begin
      n_fail++;
      $error("FAIL sipo_1011 observed=%b expected=%b", sipo_q, 4'b1011);
    end
    // back-to-back 1100 then 0110
    din = 4'b1100; load_valid = 1'b1;
    tick();
    din = 4'b0110;
    bits = 8'b1100_0110;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_bit%0d", i), {bits[7-i], 1'b1, i == 3 || i == 7, i == 3 || i == 7});
      if (i == 4) load_valid = 1'b0;
      tick();
    end
    chk("b2b_idle", 4'b0001);
    n_run++;
    assert (sipo_q === 4'b0110) else begin
      n_fail++;
      $error("FAIL sipo_0110 observed=%b expected=%b", sipo_q, 4'b0110);
    end
    // load_valid while busy is ignored
    din = 4'b0101; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk("ign_bit0", 4'b0100);
    tick();
    din = 4'b1111; load_valid = 1'b1;
    chk("ign_bit1", 4'b1100);
    tick();
    load_valid = 1'b0;
    chk("ign_bit2", 4'b0100);
    tick();
    chk("ign_bit3", 4'b1111);
    tick();
    chk("ign_idle", 4'b0001);
    // reset mid-frame
    din = 4'b1010; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk("rst_bit0", 4'b1100);
    tick();
    chk("rst_bit1", 4'b0100);
    #2 reset = 1'b1;
    #1 chk("rst_async", 4'b0001);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_idle1", 4'b0001);
    tick();
    chk("rst_idle2", 4'b0001);
    din = 4'b0001; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    w = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("w0001_bit%0d", i), {w[3-i], 1'b1, i == 3, i == 3});
      tick();
    end
    chk("w0001_idle", 4'b0001);
`ifdef SHIFT_SERIALIZER_PARITY_EN
    din = 4'b0111; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    w = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("par_bit%0d", i), {w[3-i], 1'b1, 1'b0, 1'b0});
      tick();
    end
    chk("par_parity", 4'b1111);
    tick();
    chk("par_idle", 4'b0001);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
